// File: rtl/bus_pkg.sv
// Shared types for bus arbiters: arbitration FSM states and bus direction codes.
// No logic; latency n/a; no backpressure.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWNED   = 2'd1,
        RELEASE = 2'd2
    } bus_state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/rr_bus_arbiter_if.sv
// Core-side and memory-side signals of the shared bus; master = cores/memory, slave = arbiter.
// Wires only; latency n/a; grants are the only backpressure (a core waits while ungranted).
interface rr_bus_arbiter_if #(
    parameter int N_CORES = 2,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8
);
    localparam int OWNER_W = $clog2(N_CORES);

    logic [N_CORES-1:0]        core_request;
    logic [N_CORES-1:0]        core_grant;
    logic [N_CORES-1:0]        core_rw;
    logic [N_CORES*ADDR_W-1:0] core_address;
    logic [N_CORES*DATA_W-1:0] core_wdata;
    logic [N_CORES*DATA_W-1:0] core_rdata;
    logic [ADDR_W-1:0]         mem_address;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      mem_rw;
    logic [OWNER_W-1:0]        bus_owner;
    logic                      bus_busy;
    logic                      preempt_pulse;

    modport master (
        output core_request, core_rw, core_address, core_wdata, mem_rdata,
        input  core_grant, core_rdata, mem_address, mem_wdata, mem_rw,
               bus_owner, bus_busy, preempt_pulse
    );

    modport slave (
        input  core_request, core_rw, core_address, core_wdata, mem_rdata,
        output core_grant, core_rdata, mem_address, mem_wdata, mem_rw,
               bus_owner, bus_busy, preempt_pulse
    );

endinterface

// File: rtl/rr_picker.sv
// Round-robin picker: first requester above last_owner, wrapping to the lowest index.
// Purely combinational, zero latency; no backpressure (valid low when nobody requests).
module rr_picker #(
    parameter int N       = 2,
    parameter int OWNER_W = $clog2(N)
) (
    input  logic [N-1:0]       req,
    input  logic [OWNER_W-1:0] last_owner,
    output logic [OWNER_W-1:0] winner,
    output logic               valid
);

    logic [OWNER_W-1:0] hi_idx;
    logic [OWNER_W-1:0] lo_idx;
    logic               hi_vld;
    logic               lo_vld;

    // Scan downward so the last hit is the lowest index in each region.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_vld = 1'b0;
        lo_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (OWNER_W'(i) > last_owner) begin
                    hi_vld = 1'b1;
                    hi_idx = OWNER_W'(i);
                end
                lo_vld = 1'b1;
                lo_idx = OWNER_W'(i);
            end
        end
    end

    assign winner = hi_vld ? hi_idx : lo_idx;
    assign valid  = lo_vld;

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter of N_CORES masters onto one memory port, with hold-time preemption.
// Grant one cycle after request; one dead turnaround cycle between owners; ungranted cores simply wait.
module rr_bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_CORES  = 2,
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    rr_bus_arbiter_if.slave  bus
);

    localparam int OWNER_W = $clog2(N_CORES);
    localparam int HOLD_W  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    bus_state_t         state_q,      state_d;
    logic [N_CORES-1:0] grant_q,      grant_d;
    logic [OWNER_W-1:0] owner_q,      owner_d;
    logic [OWNER_W-1:0] last_owner_q, last_owner_d;
    logic [HOLD_W-1:0]  hold_q,       hold_d;
    logic               pulse_q,      pulse_d;

    logic [OWNER_W-1:0] pick_idx;
    logic               pick_vld;
    logic [HOLD_W-1:0]  hold_inc;
    logic               others_req;

    rr_picker #(
        .N       (N_CORES),
        .OWNER_W (OWNER_W)
    ) u_picker (
        .req        (bus.core_request),
        .last_owner (last_owner_q),
        .winner     (pick_idx),
        .valid      (pick_vld)
    );

    assign hold_inc   = (hold_q == HOLD_W'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
    assign others_req = |(bus.core_request & ~grant_q);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        hold_d       = hold_q;
        pulse_d      = 1'b0;
        case (state_q)
            OWNED: begin
                hold_d = hold_inc;
                if (!bus.core_request[owner_q] ||
                    ((MAX_HOLD != 0) && (hold_inc == HOLD_W'(MAX_HOLD)) && others_req)) begin
                    state_d      = RELEASE;
                    grant_d      = '0;
                    owner_d      = '0;
                    last_owner_d = owner_q;
                    hold_d       = '0;
                    pulse_d      = bus.core_request[owner_q];
                end
            end
            default: begin
                // IDLE and RELEASE both arbitrate; RELEASE already sees the departing owner as last.
                hold_d = '0;
                if (pick_vld) begin
                    state_d = OWNED;
                    grant_d = {{(N_CORES-1){1'b0}}, 1'b1} << pick_idx;
                    owner_d = pick_idx;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    owner_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= OWNER_W'(N_CORES - 1);
            hold_q       <= '0;
            pulse_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            hold_q       <= hold_d;
            pulse_q      <= pulse_d;
        end
    end

    always_comb begin
        bus.mem_address = '0;
        bus.mem_wdata   = '0;
        bus.mem_rw      = RW_READ;
        bus.core_rdata  = '0;
        if (state_q == OWNED) begin
            bus.mem_address = bus.core_address[owner_q*ADDR_W +: ADDR_W];
            bus.mem_wdata   = bus.core_wdata[owner_q*DATA_W +: DATA_W];
            bus.mem_rw      = bus.core_rw[owner_q];
        end
        for (int i = 0; i < N_CORES; i++) begin
            if (grant_q[i]) begin
                bus.core_rdata[i*DATA_W +: DATA_W] = bus.mem_rdata;
            end
        end
    end

    assign bus.core_grant    = grant_q;
    assign bus.bus_owner     = owner_q;
    assign bus.bus_busy      = |grant_q;
    assign bus.preempt_pulse = pulse_q;

endmodule
